// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU result-path sequencer.
//   op_e     : 3-bit opcode, AND..MULT plus the illegal code 7
//   state_e  : sequencer states IDLE / EXEC / RESP
//   SEL_W    : width of the one-hot output-mux select
//   CNT_W    : width of the EXEC cycle counter (holds up to 15)
package alu_pkg;

   localparam int SEL_W           = 7;
   localparam int MULT_CYCLES_DEF = 4;
   localparam int CNT_W           = 4;

   typedef enum logic [2:0] {
      OP_AND     = 3'd0,
      OP_OR      = 3'd1,
      OP_XOR     = 3'd2,
      OP_NOT     = 3'd3,
      OP_ADD     = 3'd4,
      OP_SUB     = 3'd5,
      OP_MULT    = 3'd6,
      OP_ILLEGAL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response handshake, operand and select bundle
// between the control side, the sequencer and the ALU datapath.
//   slave  : the sequencer (takes requests and mux_out, drives operands,
//            select and the response)
//   master : the environment (requester, consumer and datapath)
interface alu_sequencer_if #(
   parameter int K = 7
) ();
   import alu_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [K-1:0]     req_a;
   logic [K-1:0]     req_b;
   logic [K-1:0]     alu_a;
   logic [K-1:0]     alu_b;
   logic [SEL_W-1:0] sel;
   logic [K-1:0]     mux_out;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [K-1:0]     rsp_data;
   logic             rsp_err;
   logic             busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, mux_out, rsp_ready,
      output req_ready, alu_a, alu_b, sel, rsp_valid, rsp_data, rsp_err, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, mux_out, rsp_ready,
      input  req_ready, alu_a, alu_b, sel, rsp_valid, rsp_data, rsp_err, busy
   );

endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode decoder.
//   op      in  3      opcode
//   sel     out SEL_W  one-hot select, bit n for opcode n; zero for illegal
//   illegal out 1      opcode has no functional unit
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [2:0]       op,
   output logic [SEL_W-1:0] sel,
   output logic             illegal
);

   always_comb begin
      sel     = '0;
      illegal = (op == OP_ILLEGAL);
      for (int unsigned i = 0; i < SEL_W; i++) begin
         if (op == 3'(i)) begin
            sel[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request at a time, registers the operands,
// holds the one-hot mux select for 1 cycle (MULT_CYCLES for multiply),
// captures the mux output and returns it on the response channel.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of alu_sequencer_if (request, operands, select,
//        mux result, response, busy)
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int K           = 7,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
   input logic            clk,
   input logic            rst,
   alu_sequencer_if.slave bus
);

   state_e           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [K-1:0]     alu_a_q,    alu_a_d;
   logic [K-1:0]     alu_b_q,    alu_b_d;
   logic [SEL_W-1:0] sel_q,      sel_d;
   logic [K-1:0]     rsp_data_q, rsp_data_d;
   logic             rsp_err_q,  rsp_err_d;

   logic [SEL_W-1:0] dec_sel;
   logic             dec_illegal;

   alu_op_decode u_decode (
      .op      (bus.req_op),
      .sel     (dec_sel),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         sel_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         sel_q      <= sel_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // The opcode register is kept in decoded one-hot form (sel_q), so the
   // select comes straight from a flop and never glitches through a decoder.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      sel_d      = sel_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               alu_a_d = bus.req_a;
               alu_b_d = bus.req_b;
               if (dec_illegal) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = ST_RESP;
               end else begin
                  sel_d   = dec_sel;
                  cnt_d   = (bus.req_op == OP_MULT) ? CNT_W'(MULT_CYCLES) : CNT_W'(1);
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            // <= also catches a zero count so the FSM can never stall here
            if (cnt_q <= CNT_W'(1)) begin
               rsp_data_d = bus.mux_out;
               rsp_err_d  = 1'b0;
               sel_d      = '0;
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == ST_IDLE);
      bus.rsp_valid = (state_q == ST_RESP);
      bus.busy      = (state_q != ST_IDLE);
      bus.alu_a     = alu_a_q;
      bus.alu_b     = alu_b_q;
      bus.sel       = sel_q;
      bus.rsp_data  = rsp_data_q;
      bus.rsp_err   = rsp_err_q;
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random checks of alu_sequencer (K=7,
// MULT_CYCLES=4) with a behavioural output mux and functional units.
module tb_alu_sequencer;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   alu_sequencer_if #(.K(7)) bus ();

   alu_sequencer #(
      .K           (7),
      .MULT_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output mux and functional units driven by the registered operands
   always_comb begin
      case (bus.sel)
         7'h01:   bus.mux_out = bus.alu_a & bus.alu_b;
         7'h02:   bus.mux_out = bus.alu_a | bus.alu_b;
         7'h04:   bus.mux_out = bus.alu_a ^ bus.alu_b;
         7'h08:   bus.mux_out = ~bus.alu_a;
         7'h10:   bus.mux_out = bus.alu_a + bus.alu_b;
         7'h20:   bus.mux_out = bus.alu_a - bus.alu_b;
         7'h40:   bus.mux_out = bus.alu_a * bus.alu_b;
         default: bus.mux_out = '0;
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] ref_result(input logic [2:0] op, input logic [6:0] a, input logic [6:0] b);
      logic [13:0] p;
      p = 14'(a) * 14'(b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~a;
         3'd4:    return a + b;
         3'd5:    return a - b;
         3'd6:    return p[6:0];
         default: return 7'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      check_val("sel_onehot0", 32'($onehot0(bus.sel)), 32'd1);
   end

   // One full transaction with rsp_ready high; exp_lat is accept edge to
   // rsp_valid in cycles, exp_sel the one-hot select expected during EXEC.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [6:0] a,
                         input logic [6:0] b, input logic [6:0] exp_data, input logic exp_err,
                         input int exp_lat, input logic [6:0] exp_sel);
      int         lat;
      int         sel_cnt;
      logic [6:0] sel_seen;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = 1'b1;
      check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check_val({tag, "_alu_a"}, 32'(bus.alu_a), 32'(a));
      check_val({tag, "_alu_b"}, 32'(bus.alu_b), 32'(b));
      lat      = 0;
      sel_cnt  = 0;
      sel_seen = '0;
      while (bus.rsp_valid !== 1'b1 && lat < 40) begin
         if (bus.sel != '0) sel_cnt++;
         sel_seen |= bus.sel;
         check_val({tag, "_exec_req_ready"}, 32'(bus.req_ready), 32'd0);
         tick();
         lat++;
      end
      check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_sel_cycles"}, 32'(sel_cnt), (exp_sel != '0) ? 32'(exp_lat) : 32'd0);
      check_val({tag, "_sel_value"}, 32'(sel_seen), 32'(exp_sel));
      check_val({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
      check_val({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
      check_val({tag, "_resp_sel"}, 32'(bus.sel), 32'd0);
      tick();
      check_val({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
      check_val({tag, "_done_ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] r_op;
      logic [6:0] r_a;
      logic [6:0] r_b;
      int         seen_valid;

      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      tick();
      tick();
      check_val("rst_sel", 32'(bus.sel), 32'd0);
      check_val("rst_alu_a", 32'(bus.alu_a), 32'd0);
      check_val("rst_alu_b", 32'(bus.alu_b), 32'd0);
      check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check_val("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      tick();
      check_val("post_rst_ready", 32'(bus.req_ready), 32'd1);

      run_op("add",  3'd4, 7'd5,  7'd3,  7'd8,  1'b0, 1, 7'h10);
      run_op("mult", 3'd6, 7'd6,  7'd7,  7'd42, 1'b0, 4, 7'h40);
      run_op("ill",  3'd7, 7'd9,  7'd2,  7'd0,  1'b1, 0, 7'h00);
      run_op("and",  3'd0, 7'h55, 7'h0F, 7'h05, 1'b0, 1, 7'h01);
      run_op("not",  3'd3, 7'h0F, 7'h33, 7'h70, 1'b0, 1, 7'h08);
      run_op("or",   3'd1, 7'h50, 7'h05, 7'h55, 1'b0, 1, 7'h02);

      // Backpressure: SUB held in RESP, a second request waits behind it
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd5;
      bus.req_a     = 7'd10;
      bus.req_b     = 7'd4;
      bus.rsp_ready = 1'b0;
      tick();
      bus.req_op = 3'd4;
      bus.req_a  = 7'd1;
      bus.req_b  = 7'd1;
      tick();
      for (int i = 0; i < 5; i++) begin
         check_val("bp_valid", 32'(bus.rsp_valid), 32'd1);
         check_val("bp_data", 32'(bus.rsp_data), 32'd6);
         check_val("bp_req_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      check_val("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("bp_hs_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      check_val("bp_next_sel", 32'(bus.sel), 32'h10);
      tick();
      check_val("bp_next_data", 32'(bus.rsp_data), 32'd2);
      check_val("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
      tick();

      // Reset during the second EXEC cycle of a MULT
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd6;
      bus.req_a     = 7'd3;
      bus.req_b     = 7'd5;
      tick();
      bus.req_valid = 1'b0;
      tick();
      check_val("mrst_pre_sel", 32'(bus.sel), 32'h40);
      #2;
      rst = 1'b1;
      #1;
      check_val("mrst_sel", 32'(bus.sel), 32'd0);
      check_val("mrst_alu_a", 32'(bus.alu_a), 32'd0);
      check_val("mrst_alu_b", 32'(bus.alu_b), 32'd0);
      check_val("mrst_busy", 32'(bus.busy), 32'd0);
      check_val("mrst_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("mrst_data", 32'(bus.rsp_data), 32'd0);
      tick();
      rst = 1'b0;
      seen_valid = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.rsp_valid) seen_valid++;
         tick();
      end
      check_val("mrst_no_rsp", 32'(seen_valid), 32'd0);
      run_op("xor", 3'd2, 7'h7F, 7'h01, 7'h7E, 1'b0, 1, 7'h04);

      for (int i = 0; i < 200; i++) begin
         r_op = 3'($urandom_range(7));
         r_a  = 7'($urandom);
         r_b  = 7'($urandom);
         run_op("rnd", r_op, r_a, r_b, ref_result(r_op, r_a, r_b), r_op == 3'd7,
                (r_op == 3'd7) ? 0 : ((r_op == 3'd6) ? 4 : 1),
                (r_op == 3'd7) ? 7'h00 : (7'h01 << r_op));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
